// File: rtl/guess_search_4bits_pkg.sv
// Shared definitions for the 4-bit guess/search block.
//   - state_e   : search FSM states
//   - WIDTH     : guess/target width (fixed at 4)
//   - MAX_STEPS : guess budget per search
//   - LO_INIT / HI_INIT / MID_INIT : search window and first guess loaded on start
package guess_search_4bits_pkg;

  localparam int WIDTH     = 4;
  localparam int MAX_STEPS = 5;

  localparam logic [WIDTH-1:0] LO_INIT  = 4'd0;
  localparam logic [WIDTH-1:0] HI_INIT  = 4'd15;
  localparam logic [WIDTH-1:0] MID_INIT = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUESS = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

endpackage

// File: rtl/guess_search_4bits.sv
// Binary search of a hidden 4-bit target through an external comparator.
// Each GUESS cycle presents a candidate on guess; the comparator answers
// combinationally and the answer is sampled on the closing clock edge.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : begin a new search (honoured in IDLE, DONE, ERR only)
//   a_lt_b      : comparator says guess < target
//   a_gt_b      : comparator says guess > target
//   a_eq_b      : comparator says guess == target
//   guess       : current candidate (comparator "a" operand)
//   guess_valid : candidate presented and being sampled
//   value       : found target, meaningful while done=1
//   steps       : guesses issued in the current/last search (saturates at 7)
//   busy        : search in progress
//   done        : target found (level)
//   err         : search failed or comparator misbehaved (level)
module guess_search_4bits #(
  parameter int WIDTH     = 4,
  parameter int MAX_STEPS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_lt_b,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  output logic [WIDTH-1:0] value,
  output logic [2:0]       steps,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import guess_search_4bits_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [2:0]       steps_q, steps_d;

  // Combinational helpers for the sample in GUESS
  logic [2:0]       flags;
  logic             flags_onehot;
  logic [2:0]       steps_inc;
  logic             last_sample;
  logic [WIDTH:0]   lo_upd;
  logic [WIDTH:0]   hi_upd;
  logic [WIDTH:0]   mid_sum;

  assign flags        = {a_lt_b, a_gt_b, a_eq_b};
  assign flags_onehot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign steps_inc    = (steps_q == 3'd7) ? 3'd7 : steps_q + 3'd1;
  assign last_sample  = (steps_inc == 3'(MAX_STEPS));

  // Narrowed window after this sample; 5 bits so guess+1 at 15 cannot wrap
  // and lo>hi can be detected directly.
  always_comb begin
    lo_upd = {1'b0, lo_q};
    hi_upd = {1'b0, hi_q};
    if (a_lt_b) begin
      lo_upd = {1'b0, guess_q} + 5'd1;
    end
    if (a_gt_b) begin
      hi_upd = {1'b0, guess_q} - 5'd1;
    end
  end

  assign mid_sum = lo_upd + hi_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= LO_INIT;
      hi_q    <= HI_INIT;
      guess_q <= '0;
      value_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      value_q <= value_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    value_d = value_q;
    steps_d = steps_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = GUESS;
          lo_d    = LO_INIT;
          hi_d    = HI_INIT;
          guess_d = MID_INIT;
          value_d = '0;
          steps_d = '0;
        end
      end

      GUESS: begin
        // Every sample counts, including a malformed one.
        steps_d = steps_inc;
        if (!flags_onehot) begin
          state_d = ERR;
        end else if (a_eq_b) begin
          value_d = guess_q;
          state_d = DONE;
        end else if (a_lt_b && (guess_q == '1)) begin
          state_d = ERR;
        end else if (a_gt_b && (guess_q == '0)) begin
          state_d = ERR;
        end else if (last_sample) begin
          state_d = ERR;
        end else if (lo_upd > hi_upd) begin
          state_d = ERR;
        end else begin
          lo_d    = lo_upd[WIDTH-1:0];
          hi_d    = hi_upd[WIDTH-1:0];
          guess_d = mid_sum[WIDTH:1];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign guess       = guess_q;
  assign value       = value_q;
  assign steps       = steps_q;
  assign busy        = (state_q == GUESS);
  assign guess_valid = (state_q == GUESS);
  assign done        = (state_q == DONE);
  assign err         = (state_q == ERR);

endmodule

// File: tb/tb_guess_search_4bits.sv
module tb_guess_search_4bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a_lt_b, a_gt_b, a_eq_b;
  logic [3:0] guess;
  logic       guess_valid;
  logic [3:0] value;
  logic [2:0] steps;
  logic       busy, done, err;

  int total;
  int bad;

  // Responder: 0 = honest comparator, 1 = lt and gt both asserted, 2 = always lt
  int         resp_mode;
  logic [3:0] target;

  guess_search_4bits #(.WIDTH(4), .MAX_STEPS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_lt_b(a_lt_b), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
    .guess(guess), .guess_valid(guess_valid), .value(value), .steps(steps),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_lt_b = 1'b0;
    a_gt_b = 1'b0;
    a_eq_b = 1'b0;
    case (resp_mode)
      0: begin
        a_lt_b = (guess < target);
        a_gt_b = (guess > target);
        a_eq_b = (guess == target);
      end
      1: begin
        a_lt_b = 1'b1;
        a_gt_b = 1'b1;
      end
      default: a_lt_b = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: what an ideal interval-halving search over [0,15] would see.
  int exp_guesses[$];
  bit exp_found;

  task automatic model(input int tgt, input int mode);
    int lo, hi, g;
    exp_guesses.delete();
    exp_found = 0;
    lo = 0; hi = 15;
    for (int n = 1; n <= 5; n++) begin
      bit lt, gt, eq;
      g = (lo + hi) / 2;
      exp_guesses.push_back(g);
      lt = (mode == 0) ? (g < tgt) : 1'b1;
      gt = (mode == 0) ? (g > tgt) : (mode == 1);
      eq = (mode == 0) ? (g == tgt) : 1'b0;
      if (int'(lt) + int'(gt) + int'(eq) != 1) return;
      if (eq) begin
        exp_found = 1;
        return;
      end
      if (lt) lo = g + 1;
      else    hi = g - 1;
      if (lo > hi || lo > 15 || hi < 0) return;
    end
  endtask

  // Runs one search from a start pulse; optionally pokes start during GUESS.
  task automatic run_search(input int tgt, input int mode, input bit poke);
    int n;
    target    = 4'(tgt);
    resp_mode = mode;
    model(tgt, mode);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_clear_on_start", int'(err), 0);
    chk("done_clear_on_start", int'(done), 0);
    n = 0;
    while (busy && n < 10) begin
      if (n < exp_guesses.size())
        chk($sformatf("guess[%0d]", n), int'(guess), exp_guesses[n]);
      chk("guess_valid", int'(guess_valid), 1);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("search_timeout", int'(n >= 10), 0);
    // done/err rising after exactly N GUESS cycles gives the N+1 edge latency
    chk("num_guesses", n, exp_guesses.size());
    chk("done", int'(done), int'(exp_found));
    chk("err", int'(err), int'(!exp_found));
    chk("steps", int'(steps), exp_guesses.size());
    if (exp_found) chk("value", int'(value), tgt);
    chk("guess_hold", int'(guess), exp_guesses[exp_guesses.size()-1]);
    $display("search tgt=%0d mode=%0d poke=%0d guesses=%0d done=%0d err=%0d value=%0d steps=%0d",
             tgt, mode, poke, n, done, err, value, steps);
  endtask

  initial begin
    total = 0;
    bad = 0;
    start = 1'b0;
    rst_n = 1'b0;
    target = 4'd0;
    resp_mode = 0;
    repeat (2) @(negedge clk);

    chk("rst_guess", int'(guess), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_steps", int'(steps), 0);
    rst_n = 1'b1;

    // Flags asserted while IDLE must not move the FSM.
    resp_mode = 1;
    repeat (3) @(negedge clk);
    chk("idle_ignores_flags", int'(busy | done | err), 0);

    run_search(7, 0, 0);
    run_search(0, 0, 0);
    run_search(15, 0, 0);
    run_search(5, 1, 0);
    run_search(9, 0, 0);   // restart out of ERR
    run_search(3, 2, 0);
    run_search(0, 0, 1);   // start pokes during GUESS

    for (int i = 0; i < 20; i++)
      run_search(int'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));

    // Reset during the second guess abandons the search.
    target = 4'd0;
    resp_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_guess2", int'(guess), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_guess", int'(guess), 0);
    chk("async_rst_busy", int'(busy | guess_valid), 0);
    chk("async_rst_flags", int'(done | err), 0);
    chk("async_rst_steps", int'(steps), 0);
    chk("async_rst_value", int'(value), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", int'(busy | done | err), 0);
    $display("reset-mid-search busy=%0d done=%0d err=%0d guess=%0d", busy, done, err, guess);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
